// File: rtl/channel_regs.sv
// Register front-end for one sound channel: decodes NRx1-NRx4 byte writes, keeps the
// length counter and channel status, and stretches trigger requests onto a 64 Hz tick.
module channel_regs (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_en,
   input  logic [1:0]  wr_addr,
   input  logic [7:0]  wr_data,
   input  logic        tick_64,
   input  logic        tick_256,
   output logic [3:0]  starting_volume,
   output logic        envelope_add,
   output logic [2:0]  period,
   output logic        trigger,
   output logic [10:0] freq,
   output logic        dac_on,
   output logic        channel_on
);

   logic [7:0]  nrx2_q, nrx2_d;
   logic [10:0] freq_q, freq_d;
   logic [6:0]  len_cnt_q, len_cnt_d;
   logic        len_en_q, len_en_d;
   logic        trigger_pend_q, trigger_pend_d;
   logic        channel_on_q, channel_on_d;

   logic        wr_nrx1, wr_nrx2, wr_nrx3, wr_nrx4, trig_evt;

   always_comb begin
      wr_nrx1  = wr_en && (wr_addr == 2'd0);
      wr_nrx2  = wr_en && (wr_addr == 2'd1);
      wr_nrx3  = wr_en && (wr_addr == 2'd2);
      wr_nrx4  = wr_en && (wr_addr == 2'd3);
      trig_evt = wr_nrx4 && wr_data[7];
   end

   always_comb begin
      nrx2_d         = nrx2_q;
      freq_d         = freq_q;
      len_cnt_d      = len_cnt_q;
      len_en_d       = len_en_q;
      channel_on_d   = channel_on_q;

      if (wr_nrx2) nrx2_d = wr_data;
      if (wr_nrx3) freq_d[7:0] = wr_data;
      if (wr_nrx4) begin
         freq_d[10:8] = wr_data[2:0];
         len_en_d     = wr_data[6];
      end

      // A pending request only clears on a tick; a repeat trigger never extends it.
      trigger_pend_d = trigger_pend_q ? !tick_64 : trig_evt;

      // Length load and trigger both outrank the 256 Hz decrement; the decrement
      // uses the len_en value from before this cycle's write.
      if (wr_nrx1) begin
         len_cnt_d = 7'd64 - {1'b0, wr_data[5:0]};
      end else if (trig_evt) begin
         if (len_cnt_q == 7'd0) len_cnt_d = 7'd64;
      end else if (tick_256 && len_en_q && (len_cnt_q != 7'd0)) begin
         len_cnt_d = len_cnt_q - 7'd1;
         if (len_cnt_q == 7'd1) channel_on_d = 1'b0;
      end

      if (trig_evt) channel_on_d = dac_on;
      if (wr_nrx2 && (wr_data[7:3] == 5'd0)) channel_on_d = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         nrx2_q         <= 8'd0;
         freq_q         <= 11'd0;
         len_cnt_q      <= 7'd0;
         len_en_q       <= 1'b0;
         trigger_pend_q <= 1'b0;
         channel_on_q   <= 1'b0;
      end else begin
         nrx2_q         <= nrx2_d;
         freq_q         <= freq_d;
         len_cnt_q      <= len_cnt_d;
         len_en_q       <= len_en_d;
         trigger_pend_q <= trigger_pend_d;
         channel_on_q   <= channel_on_d;
      end
   end

   assign starting_volume = nrx2_q[7:4];
   assign envelope_add    = nrx2_q[3];
   assign period          = nrx2_q[2:0];
   assign dac_on          = |nrx2_q[7:3];
   assign trigger         = trigger_pend_q;
   assign freq            = freq_q;
   assign channel_on      = channel_on_q;

endmodule

// File: tb/tb_channel_regs.sv
// Self-checking bench for channel_regs: directed scenarios plus random writes/ticks
// compared cycle by cycle against a behavioural model of the register rules.
module tb_channel_regs;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_en;
   logic [1:0]  wr_addr;
   logic [7:0]  wr_data;
   logic        tick_64;
   logic        tick_256;
   logic [3:0]  starting_volume;
   logic        envelope_add;
   logic [2:0]  period;
   logic        trigger;
   logic [10:0] freq;
   logic        dac_on;
   logic        channel_on;

   int errors = 0;
   int checks = 0;

   // behavioural model
   logic [7:0]  m_nrx2;
   logic [10:0] m_freq;
   int          m_len;
   bit          m_len_en, m_pend, m_on;

   channel_regs dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .tick_64(tick_64), .tick_256(tick_256), .starting_volume(starting_volume),
      .envelope_add(envelope_add), .period(period), .trigger(trigger), .freq(freq),
      .dac_on(dac_on), .channel_on(channel_on)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_nrx2 = 8'd0; m_freq = 11'd0; m_len = 0;
      m_len_en = 0; m_pend = 0; m_on = 0;
   endtask

   // Drive one cycle, let the edge happen, then advance the model by the same rules.
   task automatic step(input bit we, input logic [1:0] a, input logic [7:0] d,
                       input bit t64, input bit t256);
      bit trig;
      wr_en = we; wr_addr = a; wr_data = d; tick_64 = t64; tick_256 = t256;
      @(posedge clk); #1;
      wr_en = 0; wr_addr = 2'd0; wr_data = 8'd0; tick_64 = 0; tick_256 = 0;
      trig = we && (a == 2'd3) && d[7];
      if (m_pend) m_pend = !t64; else m_pend = trig;
      if (we && a == 2'd0) begin
         m_len = 64 - int'(d[5:0]);
      end else if (trig) begin
         if (m_len == 0) m_len = 64;
      end else if (t256 && m_len_en && m_len != 0) begin
         m_len = m_len - 1;
         if (m_len == 0) m_on = 0;
      end
      if (trig) m_on = (m_nrx2[7:3] != 0);
      if (we && a == 2'd1) begin
         m_nrx2 = d;
         if (d[7:3] == 0) m_on = 0;
      end
      if (we && a == 2'd2) m_freq[7:0] = d;
      if (we && a == 2'd3) begin
         m_freq[10:8] = d[2:0];
         m_len_en = d[6];
      end
   endtask

   task automatic idle();
      step(0, 2'd0, 8'd0, 0, 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();
      idle();
   endtask

   // Ticks tick_256 until channel_on drops; returns number of ticks (or -1 on timeout).
   task automatic count_ticks(output int n);
      n = -1;
      for (int i = 1; i <= 200; i++) begin
         step(0, 2'd0, 8'd0, 0, 1);
         if (channel_on === 1'b0) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({starting_volume, envelope_add, period, trigger, freq, dac_on, channel_on} !== 21'd0) begin
         errors++;
         $display("FAIL reset_values: got %h expected 0",
                  {starting_volume, envelope_add, period, trigger, freq, dac_on, channel_on});
      end
      step(1, 2'd1, 8'hF1, 0, 0);
      step(1, 2'd2, 8'h5A, 0, 0);
      step(1, 2'd3, 8'h83, 0, 0);
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({starting_volume, envelope_add, period, trigger, freq, dac_on, channel_on} !== 21'd0) begin
         errors++;
         $display("FAIL reset_async: got %h expected 0",
                  {starting_volume, envelope_add, period, trigger, freq, dac_on, channel_on});
      end
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();
      for (int i = 0; i < 5; i++) idle();
      checks++;
      if ({trigger, channel_on, dac_on, freq} !== 14'd0) begin
         errors++;
         $display("FAIL reset_release: trig=%b on=%b dac=%b freq=%h expected all 0",
                  trigger, channel_on, dac_on, freq);
      end
      $display("test_reset done");
   endtask

   task automatic test_nrx2_decode();
      do_reset();
      step(1, 2'd1, 8'h8B, 0, 0);
      checks++;
      if ({starting_volume, envelope_add, period, dac_on} !== {4'd8, 1'b1, 3'd3, 1'b1}) begin
         errors++;
         $display("FAIL nrx2_8b: vol=%0d add=%b per=%0d dac=%b expected 8 1 3 1",
                  starting_volume, envelope_add, period, dac_on);
      end
      step(1, 2'd3, 8'h80, 0, 0);
      step(1, 2'd1, 8'h07, 0, 0);
      checks++;
      if ({dac_on, channel_on, period} !== {1'b0, 1'b0, 3'd7}) begin
         errors++;
         $display("FAIL nrx2_07: dac=%b on=%b per=%0d expected 0 0 7", dac_on, channel_on, period);
      end
      step(1, 2'd2, 8'hC3, 0, 0);
      step(1, 2'd3, 8'h05, 0, 0);
      checks++;
      if (freq !== 11'h5C3) begin
         errors++;
         $display("FAIL freq: got %h expected 5c3", freq);
      end
      $display("test_nrx2_decode done");
   endtask

   task automatic test_trigger_stretch();
      do_reset();
      step(1, 2'd1, 8'hF1, 0, 0);
      step(1, 2'd3, 8'h80, 0, 0);
      checks++;
      if ({trigger, channel_on} !== 2'b11) begin
         errors++;
         $display("FAIL trig_start: trig=%b on=%b expected 1 1", trigger, channel_on);
      end
      idle(); idle();
      step(1, 2'd3, 8'h80, 0, 0);
      idle();
      checks++;
      if (trigger !== 1'b1) begin
         errors++;
         $display("FAIL trig_hold: trig=%b expected 1", trigger);
      end
      step(0, 2'd0, 8'd0, 1, 0);
      checks++;
      if (trigger !== 1'b0) begin
         errors++;
         $display("FAIL trig_clear: trig=%b expected 0", trigger);
      end
      idle();
      checks++;
      if (trigger !== 1'b0) begin
         errors++;
         $display("FAIL trig_no_extend: trig=%b expected 0", trigger);
      end
      step(1, 2'd3, 8'h80, 1, 0);
      idle();
      checks++;
      if (trigger !== 1'b1) begin
         errors++;
         $display("FAIL trig_with_tick: trig=%b expected 1", trigger);
      end
      step(0, 2'd0, 8'd0, 1, 0);
      checks++;
      if (trigger !== 1'b0) begin
         errors++;
         $display("FAIL trig_with_tick_clear: trig=%b expected 0", trigger);
      end
      $display("test_trigger_stretch done");
   endtask

   task automatic test_trigger_dac_off();
      do_reset();
      step(1, 2'd1, 8'h00, 0, 0);
      step(1, 2'd3, 8'h80, 0, 0);
      checks++;
      if ({trigger, channel_on} !== 2'b10) begin
         errors++;
         $display("FAIL trig_dac_off: trig=%b on=%b expected 1 0", trigger, channel_on);
      end
      $display("test_trigger_dac_off done");
   endtask

   task automatic test_length_expiry();
      int n;
      do_reset();
      step(1, 2'd1, 8'hF0, 0, 0);
      step(1, 2'd0, 8'h3E, 0, 0);
      step(1, 2'd3, 8'hC0, 0, 0);
      checks++;
      if (channel_on !== 1'b1) begin
         errors++;
         $display("FAIL len_start: on=%b expected 1", channel_on);
      end
      step(0, 2'd0, 8'd0, 0, 1);
      checks++;
      if (channel_on !== 1'b1) begin
         errors++;
         $display("FAIL len_tick1: on=%b expected 1", channel_on);
      end
      step(0, 2'd0, 8'd0, 0, 1);
      checks++;
      if (channel_on !== 1'b0) begin
         errors++;
         $display("FAIL len_tick2: on=%b expected 0", channel_on);
      end
      step(0, 2'd0, 8'd0, 0, 1);
      step(1, 2'd3, 8'hC0, 0, 0);
      count_ticks(n);
      checks++;
      if (n != 64) begin
         errors++;
         $display("FAIL len_no_wrap: ticks=%0d expected 64", n);
      end
      $display("test_length_expiry done");
   endtask

   task automatic test_priority();
      int n;
      do_reset();
      step(1, 2'd1, 8'hF0, 0, 0);
      step(1, 2'd3, 8'hC0, 0, 0);
      step(0, 2'd0, 8'd0, 0, 1);
      step(0, 2'd0, 8'd0, 0, 1);
      step(1, 2'd0, 8'h00, 0, 1);
      count_ticks(n);
      checks++;
      if (n != 64) begin
         errors++;
         $display("FAIL prio_load_vs_tick: ticks=%0d expected 64", n);
      end
      step(1, 2'd0, 8'h3F, 0, 0);
      step(1, 2'd3, 8'hC0, 0, 1);
      checks++;
      if (channel_on !== 1'b1) begin
         errors++;
         $display("FAIL prio_trig_vs_expiry: on=%b expected 1", channel_on);
      end
      step(0, 2'd0, 8'd0, 0, 1);
      checks++;
      if (channel_on !== 1'b0) begin
         errors++;
         $display("FAIL prio_len_kept_1: on=%b expected 0", channel_on);
      end
      step(1, 2'd0, 8'h3F, 0, 0);
      step(1, 2'd3, 8'h80, 0, 0);
      step(1, 2'd3, 8'h40, 0, 1);
      checks++;
      if (channel_on !== 1'b1) begin
         errors++;
         $display("FAIL prio_len_en_late: on=%b expected 1", channel_on);
      end
      step(0, 2'd0, 8'd0, 0, 1);
      checks++;
      if (channel_on !== 1'b0) begin
         errors++;
         $display("FAIL prio_len_en_active: on=%b expected 0", channel_on);
      end
      $display("test_priority done");
   endtask

   task automatic test_random();
      logic [20:0] exp_v, got_v;
      bit we;
      logic [1:0] a;
      logic [7:0] d;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         we = ($urandom_range(0, 2) == 0);
         a  = 2'($urandom_range(0, 3));
         d  = 8'($urandom);
         if (a == 2'd0) d[5:0] = 6'($urandom_range(58, 63));
         if (a == 2'd1 && $urandom_range(0, 3) == 0) d[7:3] = 5'd0;
         step(we, a, d, $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0);
         exp_v = {m_nrx2[7:4], m_nrx2[3], m_nrx2[2:0], m_pend, m_freq, (m_nrx2[7:3] != 0), m_on};
         got_v = {starting_volume, envelope_add, period, trigger, freq, dac_on, channel_on};
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL random_cycle %0d: got %h expected %h", i, got_v, exp_v);
         end
      end
      $display("test_random done");
   endtask

   initial begin
      reset = 1'b1; wr_en = 0; wr_addr = 2'd0; wr_data = 8'd0; tick_64 = 0; tick_256 = 0;
      model_reset();
      #12;
      test_reset();
      test_nrx2_decode();
      test_trigger_stretch();
      test_trigger_dac_off();
      test_length_expiry();
      test_priority();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
